// File: rtl/updown_ctr_seq.sv
// -----------------------------------------------------------------------------
// updown_ctr_seq
//
// Command-driven initiator for the updown_ctr control interface.  Commands
// (LOAD / UP / DOWN / WAIT) arrive over a valid/ready handshake.  They are
// turned into cycle-accurate, registered load/din/up/enable strobes for the
// counter.  A reference model of the expected count runs alongside.  Any
// disagreement with the counter's count output raises a sticky error flag.
//
// Parameters
//   WIDTH     counter data width (din, count, exp_count)
//   LEN_W     width of the command cycle-count field
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE only)
//   cmd_op     00=LOAD, 01=UP, 10=DOWN, 11=WAIT
//   cmd_data   load value (LOAD only)
//   cmd_len    number of active cycles (UP/DOWN/WAIT)
//   load       counter load strobe
//   din        counter load data (holds the last loaded value)
//   up         counter direction, 1=increment (holds outside RUN)
//   enable     counter count enable
//   count      counter output feedback
//   busy       command in progress
//   done       one-cycle pulse in the first IDLE cycle after a command
//   exp_count  model of the expected counter value
//   chk_valid  model is valid (set by the first LOAD)
//   err        sticky mismatch flag
//   err_clr    synchronous clear of err (a coincident mismatch wins)
// -----------------------------------------------------------------------------
module updown_ctr_seq #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             load,
   output logic [WIDTH-1:0] din,
   output logic             up,
   output logic             enable,
   input  logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] exp_count,
   output logic             chk_valid,
   output logic             err,
   input  logic             err_clr
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_WAIT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   len_reg, len_next;

   logic               load_reg, load_next;
   logic [WIDTH-1:0]   din_reg, din_next;
   logic               up_reg, up_next;
   logic               enable_reg, enable_next;
   logic               done_reg, done_next;
   logic [WIDTH-1:0]   exp_count_reg, exp_count_next;
   logic               chk_valid_reg, chk_valid_next;
   logic               err_reg, err_next;

   logic               accept;
   logic               len_zero;
   logic               last_cycle;
   logic               mismatch;

   // Ready is forced low while reset is held so that every output reads 0
   // during reset and ready appears as soon as reset is released.
   assign cmd_ready  = reset & (state_reg == ST_IDLE);
   assign accept     = cmd_valid & cmd_ready;
   assign len_zero   = (cmd_len == '0);

   // The remaining-cycle counter holds the number of active cycles still to
   // come, including the current one, so a value of 1 marks the final cycle.
   assign last_cycle = (state_reg == ST_LOAD) ||
                       (((state_reg == ST_RUN) || (state_reg == ST_WAIT)) &&
                        (len_reg == LEN_W'(1)));

   // The checker is live in every state once the model holds a loaded value.
   assign mismatch   = chk_valid_reg && (count != exp_count_reg);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         load_reg      <= 1'b0;
         din_reg       <= '0;
         up_reg        <= 1'b0;
         enable_reg    <= 1'b0;
         done_reg      <= 1'b0;
         exp_count_reg <= '0;
         chk_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         load_reg      <= load_next;
         din_reg       <= din_next;
         up_reg        <= up_next;
         enable_reg    <= enable_next;
         done_reg      <= done_next;
         exp_count_reg <= exp_count_next;
         chk_valid_reg <= chk_valid_next;
         err_reg       <= err_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               unique case (cmd_op)
                  OP_LOAD: state_next = ST_LOAD;
                  OP_UP, OP_DOWN: begin
                     // A zero-length command has no active cycle at all;
                     // it stays in IDLE and only produces the done pulse.
                     if (!len_zero) begin
                        state_next = ST_RUN;
                        len_next   = cmd_len;
                     end
                  end
                  OP_WAIT: begin
                     if (!len_zero) begin
                        state_next = ST_WAIT;
                        len_next   = cmd_len;
                     end
                  end
                  default: state_next = ST_IDLE;
               endcase
            end
         end
         ST_LOAD: begin
            state_next = ST_IDLE;
         end
         ST_RUN, ST_WAIT: begin
            len_next = len_reg - LEN_W'(1);
            if (last_cycle) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            len_next   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: computes the values the registered outputs take at the
   // next edge, so every counter strobe is driven straight from a flop.
   // -------------------------------------------------------------------------
   always_comb begin
      load_next      = (state_next == ST_LOAD);
      enable_next    = (state_next == ST_RUN);
      din_next       = din_reg;
      up_next        = up_reg;
      exp_count_next = exp_count_reg;
      chk_valid_next = chk_valid_reg;

      // Load data and direction are captured only at the accepting edge.
      if (accept && (cmd_op == OP_LOAD)) begin
         din_next = cmd_data;
      end
      if (accept && (state_next == ST_RUN)) begin
         up_next = (cmd_op == OP_UP);
      end

      // The model moves on the closing edge of each active cycle, the same
      // edge on which the counter itself updates.
      unique case (state_reg)
         ST_LOAD: begin
            exp_count_next = din_reg;
            chk_valid_next = 1'b1;
         end
         ST_RUN: begin
            exp_count_next = up_reg ? (exp_count_reg + WIDTH'(1))
                                    : (exp_count_reg - WIDTH'(1));
         end
         default: begin
            exp_count_next = exp_count_reg;
         end
      endcase

      // done marks the first IDLE cycle after a command: either the final
      // active cycle closes, or a zero-length command was just accepted.
      done_next = last_cycle ||
                  (accept && (cmd_op != OP_LOAD) && len_zero);

      // Sticky error: a mismatch takes priority over a coincident clear.
      err_next = mismatch | (err_reg & ~err_clr);
   end

   assign load      = load_reg;
   assign din       = din_reg;
   assign up        = up_reg;
   assign enable    = enable_reg;
   assign done      = done_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign exp_count = exp_count_reg;
   assign chk_valid = chk_valid_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_updown_ctr_seq.sv
module tb_updown_ctr_seq;

   localparam int W  = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [W-1:0]  cmd_data = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          load;
   logic [W-1:0]  din;
   logic          up;
   logic          enable;
   logic [W-1:0]  count;
   logic          busy;
   logic          done;
   logic [W-1:0]  exp_count;
   logic          chk_valid;
   logic          err;
   logic          err_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   updown_ctr_seq #(.WIDTH(W), .LEN_W(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .load      (load),
      .din       (din),
      .up        (up),
      .enable    (enable),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .exp_count (exp_count),
      .chk_valid (chk_valid),
      .err       (err),
      .err_clr   (err_clr)
   );

   // Counter under control: load beats enable, wraps modulo 2^W.
   // inject adds one to the fed-back count to provoke a mismatch.
   logic [W-1:0] ctr;
   logic         inject = 1'b0;
   assign count = ctr + W'(inject);

   always @(posedge clk or negedge reset) begin
      if (!reset)      ctr <= '0;
      else if (load)   ctr <= din;
      else if (enable) ctr <= up ? ctr + W'(1) : ctr - W'(1);
   end

   // Behavioural model: a command accepted in an idle cycle owns the next
   // N cycles (N=1 for LOAD, cmd_len otherwise); the cycle after those is
   // the done cycle, itself idle.
   int           m_left;
   logic [1:0]   m_op;
   bit           m_done;
   logic [W-1:0] m_exp;
   logic [W-1:0] m_din;
   bit           m_valid;
   bit           m_err;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left <= 0; m_op <= 2'b00; m_done <= 1'b0; m_exp <= '0;
         m_din <= '0; m_valid <= 1'b0; m_err <= 1'b0;
      end else begin
         m_err <= (m_valid && (count != m_exp)) ? 1'b1 : (err_clr ? 1'b0 : m_err);
         if (m_left > 0) begin
            case (m_op)
               2'd0: begin m_exp <= m_din; m_valid <= 1'b1; end
               2'd1: m_exp <= m_exp + W'(1);
               2'd2: m_exp <= m_exp - W'(1);
               default: ;
            endcase
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
         end else begin
            m_done <= 1'b0;
            if (cmd_valid) begin
               m_op <= cmd_op;
               if (cmd_op == 2'd0) begin
                  m_left <= 1;
                  m_din  <= cmd_data;
               end else if (cmd_len == '0) begin
                  m_done <= 1'b1;
               end else begin
                  m_left <= int'(cmd_len);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      bit m_busy;
      bit m_en;
      m_busy = (m_left > 0);
      m_en   = m_busy && ((m_op == 2'd1) || (m_op == 2'd2));
      chk("cmd_ready", W'(cmd_ready), W'(reset && !m_busy));
      chk("busy",      W'(busy),      W'(m_busy));
      chk("load",      W'(load),      W'(m_busy && (m_op == 2'd0)));
      chk("enable",    W'(enable),    W'(m_en));
      if (m_en) chk("up", W'(up), W'(m_op == 2'd1));
      chk("din",       din,           m_din);
      chk("done",      W'(done),      W'(m_done));
      chk("exp_count", exp_count,     m_exp);
      chk("chk_valid", W'(chk_valid), W'(m_valid));
      chk("err",       W'(err),       W'(m_err));
   end

   // Present a command at a falling edge and hold it until accepted;
   // returns at the falling edge of the cycle after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [W-1:0] data, input int len);
      bit ok;
      ok = 1'b0;
      cmd_op = op; cmd_data = data; cmd_len = LW'(len); cmd_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (cmd_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 op=%0d", op);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Count enable/busy cycles until done, bounded.
   task automatic wait_done(output int en_cnt, output int busy_cnt);
      bit ok;
      ok = 1'b0; en_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin ok = 1'b1; break; end
         if (enable) en_cnt++;
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL done_timeout: got done=0 expected done=1");
      end
   endtask

   initial begin
      int en, bc;
      logic [W-1:0] pick;

      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", W'(cmd_ready), 32'd1);
      chk("rst_busy",  W'(busy),      32'd0);
      chk("rst_valid", W'(chk_valid), 32'd0);
      chk("rst_err",   W'(err),       32'd0);
      chk("rst_exp",   exp_count,     32'd0);

      // LOAD 0x1234
      send(2'd0, 32'h0000_1234, 0);
      chk("ld_load", W'(load),   32'd1);
      chk("ld_din",  din,        32'h1234);
      chk("ld_en",   W'(enable), 32'd0);
      @(negedge clk);
      chk("ld_done",  W'(done),      32'd1);
      chk("ld_exp",   exp_count,     32'h1234);
      chk("ld_count", count,         32'h1234);
      chk("ld_valid", W'(chk_valid), 32'd1);

      // UP 10
      send(2'd1, '0, 10);
      wait_done(en, bc);
      chk("up_en_cycles", W'(en), 32'd10);
      chk("up_exp",   exp_count, 32'h123E);
      chk("up_count", count,     32'h123E);
      @(negedge clk);
      chk("up_done_single", W'(done), 32'd0);

      // LOAD 1, DOWN 3 wraps, then WAIT 5 holds
      send(2'd0, 32'd1, 0);
      wait_done(en, bc);
      send(2'd2, '0, 3);
      wait_done(en, bc);
      chk("dn_en_cycles", W'(en), 32'd3);
      chk("dn_count", count,     32'hFFFF_FFFE);
      chk("dn_exp",   exp_count, 32'hFFFF_FFFE);
      send(2'd3, '0, 5);
      wait_done(en, bc);
      chk("wt_en_cycles",   W'(en), 32'd0);
      chk("wt_busy_cycles", W'(bc), 32'd5);
      chk("wt_count", count, 32'hFFFF_FFFE);

      // Back-to-back: UP 0 then UP 2 accepted in the done cycle
      send(2'd1, '0, 0);
      chk("b2b_done0", W'(done),   32'd1);
      chk("b2b_en0",   W'(enable), 32'd0);
      send(2'd1, '0, 2);
      wait_done(en, bc);
      chk("b2b_en_cycles", W'(en), 32'd2);
      chk("b2b_wrap_exp", exp_count, 32'd0);

      // Error path
      inject = 1'b1;
      @(negedge clk); inject = 1'b0;
      chk("err_set", W'(err), 32'd1);
      @(negedge clk);
      chk("err_sticky", W'(err), 32'd1);
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("err_clr", W'(err), 32'd0);
      inject = 1'b1; err_clr = 1'b1;
      @(negedge clk); inject = 1'b0; err_clr = 1'b0;
      chk("err_set_wins", W'(err), 32'd1);
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("err_clr2", W'(err), 32'd0);

      // Reset during UP 100
      send(2'd1, '0, 100);
      repeat (5) @(negedge clk);
      chk("pre_rst_en", W'(enable), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_en",    W'(enable),    32'd0);
      chk("mid_rst_busy",  W'(busy),      32'd0);
      chk("mid_rst_done",  W'(done),      32'd0);
      chk("mid_rst_ready", W'(cmd_ready), 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", W'(cmd_ready), 32'd1);
      chk("post_rst_done",  W'(done),      32'd0);
      chk("post_rst_valid", W'(chk_valid), 32'd0);

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0: pick = '0;
            1: pick = '1;
            default: pick = $urandom;
         endcase
         cmd_valid = ($urandom_range(0, 2) == 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_data  = pick;
         cmd_len   = LW'($urandom_range(0, 6));
         inject    = ($urandom_range(0, 99) == 0);
         err_clr   = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      cmd_valid = 1'b0; inject = 1'b0; err_clr = 1'b0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_ctr_seq.md
Name: updown_ctr_seq

Overview:
Command-driven initiator for the updown_ctr control interface. It accepts LOAD, UP, DOWN and WAIT commands over a valid/ready handshake and drives `load`, `din`, `up` and `enable` cycle-accurately. It keeps a reference model of the expected count and flags any mismatch against the counter's `count` output. It sits between the test/control logic and `updown_ctr`, replacing hand-timed task sequences.

Parameters:
WIDTH, 32, counter data width (`din`, `count`, `exp_count`)
LEN_W, 16, width of the command cycle-count field

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00=LOAD, 01=UP, 10=DOWN, 11=WAIT
cmd_data  input  WIDTH  load value (LOAD only)
cmd_len  input  LEN_W  active cycles (UP/DOWN/WAIT)
load  output  1  to counter load
din  output  WIDTH  to counter din
up  output  1  to counter up (1=increment)
enable  output  1  to counter enable
count  input  WIDTH  counter output feedback
busy  output  1  command in progress
done  output  1  one-cycle pulse on command completion
exp_count  output  WIDTH  model of expected counter value
chk_valid  output  1  model is valid (set after first LOAD)
err  output  1  sticky mismatch flag
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all outputs 0.
  - Exception: cmd_ready=1 once reset deasserts.
  - Reset asserted mid-command aborts the command immediately; no done pulse.
- States: IDLE, LOAD, RUN, WAIT.
- Handshake:
  - cmd_ready=1 only in IDLE; accept on cmd_valid&cmd_ready.
  - Command fields are captured at the accepting edge.
  - Changes to the command inputs while not ready are ignored.
- All counter-control outputs are registered. The first active cycle is the cycle after accept.
- LOAD:
  - One cycle with load=1, din=cmd_data, enable=0.
  - At that cycle's closing edge, exp_count<=cmd_data and chk_valid<=1.
  - Then IDLE.
- UP/DOWN:
  - enable=1 and up=1/0 for exactly cmd_len cycles.
  - Each cycle, exp_count ±1 modulo 2^WIDTH at the closing edge.
- WAIT: enable=0 for cmd_len cycles; exp_count holds.
- cmd_len=0 (UP/DOWN/WAIT): no active cycle; the sequencer returns to IDLE and pulses done in the cycle after accept.
- Completion:
  - done=1 for exactly the first IDLE cycle after the final active cycle.
  - cmd_ready is also 1 in that cycle, so a back-to-back accept is possible. Minimum spacing is one IDLE cycle between commands.
- busy=1 in LOAD/RUN/WAIT; 0 in IDLE.
- din holds its last loaded value; up holds its last value outside RUN. load and enable are 0 outside their active cycles.
- Checker:
  - Active every cycle with chk_valid=1 (IDLE included).
  - Compares count against exp_count combinationally; mismatch sets err at the next edge.
  - err stays 1 until err_clr=1 or reset.
  - err_clr and a coincident mismatch in the same cycle: set wins, so err=1.
- The counter contract is fixed:
  - load has priority over enable.
  - count updates on the same edge as exp_count.
  - Wrap is modulo 2^WIDTH.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, cmd_ready=1, chk_valid=0, err=0.
- LOAD 0x00001234 -> load=1 and din=0x1234 for 1 cycle; done pulse 1 cycle later; exp_count=count=0x1234; chk_valid=1; err=0.
- UP len=10 after LOAD 0x1234 -> enable=1, up=1 for exactly 10 cycles; final count=exp_count=0x123E; done single pulse; err=0.
- LOAD 0x00000001, then DOWN len=3 -> count wraps to 0xFFFFFFFE; exp_count matches; err=0. Then WAIT len=5 -> enable=0 for 5 cycles; count stays 0xFFFFFFFE.
- Back-to-back UP len=0, then UP len=2 with cmd_valid held high -> first command gives done with no enable cycle; second is accepted in the done cycle and gives 2 enable cycles.
- Error path: force count to exp_count+1 for one cycle -> err=1 next cycle and stays 1; err_clr pulse -> err=0. Reset asserted during UP len=100 -> enable drops to 0 immediately; no done pulse; state IDLE.
